// File: rtl/bcd_counter_scan_disp.sv
// bcd_counter_scan_disp
//   Multi-digit BCD up/down counter with a prescaled count tick, a parallel
//   load, a one-clock wrap carry and a scanned 7-segment driver.
//   Optional build macro: LZ_BLANK_EN. When it is defined, leading-zero digits
//   above the most significant nonzero digit are blanked. Digit 0 always shows.
module bcd_counter_scan_disp #(
  parameter int DIGITS    = 4,
  parameter int DIV_BITS  = 21,
  parameter int SCAN_BITS = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                up_dn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic                carry,
  output logic [2:0]          seg7_sel,
  output logic [6:0]          seg7_out,
  output logic                dpt_out,
  output logic                led_com
);

  // Segment pattern {g,f,e,d,c,b,a} for one BCD digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  logic [DIV_BITS-1:0]  presc_q, presc_d;
  logic [SCAN_BITS-1:0] scan_q, scan_d;
  logic [4*DIGITS-1:0]  count_q, count_d;
  logic                 carry_q, carry_d;
  logic [2:0]           sel_q, sel_d;
  logic [6:0]           seg_q, seg_d;

  logic                 tick;
  logic [3:0]           dig;
  logic                 rip;
  logic [3:0]           cur_digit;

  assign tick = &presc_q;

  // Free-running prescaler and scan counters; the scan index steps on each scan wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    presc_d = presc_q + 1'b1;
    scan_d  = scan_q + 1'b1;
    sel_d   = sel_q;
    if (&scan_q) begin
      sel_d = (sel_q == 3'(DIGITS - 1)) ? 3'd0 : sel_q + 3'd1;
    end
  end

  // Counter next state: load (saturating each digit at 9) beats a tick; a tick ripples through the digits.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    dig     = 4'd0;
    rip     = 1'b0;
    if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        dig = load_val[4*i +: 4];
        count_d[4*i +: 4] = (dig > 4'd9) ? 4'd9 : dig;
      end
    end else if (tick && enable) begin
      rip = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        dig = count_q[4*i +: 4];
        if (rip) begin
          if (up_dn) begin
            if (dig == 4'd9) dig = 4'd0;
            else begin
              dig = dig + 4'd1;
              rip = 1'b0;
            end
          end else begin
            if (dig == 4'd0) dig = 4'd9;
            else begin
              dig = dig - 4'd1;
              rip = 1'b0;
            end
          end
        end
        count_d[4*i +: 4] = dig;
      end
      // A ripple surviving past the top digit means the whole count wrapped.
      carry_d = rip;
    end
  end

  // Pick the digit that the next scan index will drive.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_d == 3'(i)) cur_digit = count_q[4*i +: 4];
    end
  end

`ifdef LZ_BLANK_EN
  logic cur_blank;
  logic nz_above;

  // A digit above 0 is blank when it and every digit above it are zero.
  always_comb begin
    cur_blank = 1'b0;
    nz_above  = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (sel_d == 3'(i)) begin
        cur_blank = (i != 0) && !nz_above && (count_q[4*i +: 4] == 4'd0);
      end
      nz_above = nz_above | (count_q[4*i +: 4] != 4'd0);
    end
  end

  assign seg_d = cur_blank ? 7'h00 : seg_decode(cur_digit);
`else
  assign seg_d = seg_decode(cur_digit);
`endif

  // State registers; index and segment pattern update on the same edge so they always match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      scan_q  <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      sel_q   <= 3'd0;
      seg_q   <= 7'h3F;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values, independent of statement order.
      presc_q <= presc_d;
      scan_q  <= scan_d;
      count_q <= count_d;
      carry_q <= carry_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign count_bcd = count_q;
  assign carry     = carry_q;
  assign seg7_sel  = sel_q;
  assign seg7_out  = seg_q;
  assign dpt_out   = 1'b0;
  assign led_com   = 1'b1;

endmodule

// File: tb/tb_bcd_counter_scan_disp.sv
// Bench for bcd_counter_scan_disp with DIGITS=2, DIV_BITS=2, SCAN_BITS=1.
// A reference model keeps the count as a plain integer 0..99 and derives
// tick and scan timing from the number of clock edges since reset.
module tb_bcd_counter_scan_disp;

  localparam int DIGITS = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       up_dn;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count_bcd;
  logic       carry;
  logic [2:0] seg7_sel;
  logic [6:0] seg7_out;
  logic       dpt_out;
  logic       led_com;

  bcd_counter_scan_disp #(
    .DIGITS   (DIGITS),
    .DIV_BITS (2),
    .SCAN_BITS(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count_bcd(count_bcd),
    .carry    (carry),
    .seg7_sel (seg7_sel),
    .seg7_out (seg7_out),
    .dpt_out  (dpt_out),
    .led_com  (led_com)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int         m_cnt;
  int         m_carry;
  int         m_sel;
  int         m_edges;
  logic [6:0] m_seg;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic int load_to_int(input logic [7:0] v);
    int hi, lo;
    hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
    lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("count_bcd", 32'(count_bcd), 32'(to_bcd(m_cnt)));
    check("carry",     32'(carry),     32'(m_carry));
    check("seg7_sel",  32'(seg7_sel),  32'(m_sel));
    check("seg7_out",  32'(seg7_out),  32'(m_seg));
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_carry = 0;
    m_sel   = 0;
    m_edges = 0;
    m_seg   = 7'h3F;
  endtask

  // Advance the model by one clock edge using the current inputs, then clock the DUT and compare.
  task automatic step();
    int  old;
    bit  tick;
    old  = m_cnt;
    tick = (m_edges % 4 == 3);
    if (m_edges % 2 == 1) m_sel = (m_sel + 1) % DIGITS;
    m_seg = seg_tab[(m_sel == 0) ? (old % 10) : (old / 10)];
`ifdef LZ_BLANK_EN
    if (m_sel == 1 && old < 10) m_seg = 7'h00;
`endif
    if (load) begin
      m_cnt   = load_to_int(load_val);
      m_carry = 0;
    end else if (tick && enable) begin
      if (up_dn) begin
        m_carry = (old == 99) ? 1 : 0;
        m_cnt   = (old + 1) % 100;
      end else begin
        m_carry = (old == 0) ? 1 : 0;
        m_cnt   = (old + 99) % 100;
      end
    end else begin
      m_carry = 0;
    end
    m_edges++;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    step();
    load     = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    enable   = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = 8'h00;
    model_reset();

    // Reset state
    #12;
    check_all();
    check("dpt_out", 32'(dpt_out), 32'h0);
    check("led_com", 32'(led_com), 32'h1);
    @(negedge clk);
    reset = 1'b1;

    // Load 98, count up across two ticks: 99 then wrap to 00 with a carry pulse
    do_load(8'h98);
    enable = 1'b1;
    up_dn  = 1'b1;
    repeat (8) step();
    check("up_wrap_count", 32'(count_bcd), 32'h00);

    // Count down from 00: wrap to 99 with carry, then 98 without carry
    up_dn = 1'b0;
    repeat (8) step();
    check("down_wrap_count", 32'(count_bcd), 32'h98);

    // Asynchronous reset mid-count: outputs clear without a clock edge
    reset = 1'b0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Hold with enable low for ten ticks while up_dn wiggles
    do_load(8'h37);
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      up_dn = 1'($urandom % 2);
      step();
    end
    check("hold_count", 32'(count_bcd), 32'h37);

    // Load on a tick cycle: digit saturates at 9 and the tick is discarded
    enable = 1'b1;
    up_dn  = 1'b1;
    while (m_edges % 4 != 3) step();
    do_load(8'h4A);
    check("load_on_tick", 32'(count_bcd), 32'h49);
    enable = 1'b0;

    // Scanned display of 57 and of 05 (leading-zero behaviour depends on build)
    do_load(8'h57);
    repeat (8) step();
    do_load(8'h05);
    repeat (8) step();

    // Randomized traffic, biased toward wrap boundaries
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom % 4) != 0;
      up_dn  = 1'($urandom % 2);
      if ($urandom % 12 == 0) begin
        case ($urandom % 3)
          0:       load_val = 8'h99;
          1:       load_val = 8'h00;
          default: load_val = 8'($urandom);
        endcase
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      step();
    end
    load = 1'b0;

    check("dpt_out_end", 32'(dpt_out), 32'h0);
    check("led_com_end", 32'(led_com), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
